// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial-pattern detector with run-time pattern reload and overlap select.
// Optional saturating match counter is built only when SEQDET_MATCH_CNT_EN is defined.
module seq_detector_param #(
    parameter int               PAT_W    = 4,
    parameter logic [PAT_W-1:0] PAT_INIT = 4'b1011,
    parameter bit               OVERLAP  = 1'b1,
    parameter int               CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             z,
    output logic [PAT_W-1:0] pat,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int               FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [PAT_W-1:0]  window;
    logic              full;
    logic              accept;

    always_comb begin
        window = {hist_q, x};
        full   = (fill_q == FILL_MAX);
        accept = x_valid & ~pat_load & ~reset;
        // fill gating keeps reset-time zeros in hist from ever matching
        z      = accept & full & (window == pat_q);

        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        if (pat_load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (x_valid) begin
            hist_d = window[PAT_W-2:0];
            if (z && !OVERLAP)
                fill_d = '0;
            else if (!full)
                fill_d = fill_q + FILL_W'(1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= PAT_INIT;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
        end
    end

    assign pat = pat_q;

`ifdef SEQDET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (pat_load)
            cnt_d = '0;
        else if (z && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1'b1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Table-driven bench for seq_detector_param: overlap, non-overlap and 2-bit-counter instances share stimulus.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset, x, x_valid, pat_load;
    logic [3:0] pat_in;

    logic       z_ov, z_no, z_sat;
    logic [3:0] pat_ov, pat_no, pat_sat;
    logic [7:0] cnt_ov, cnt_no;
    logic [1:0] cnt_sat;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_W(4), .PAT_INIT(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_ov (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pat_load(pat_load),
        .pat_in(pat_in), .z(z_ov), .pat(pat_ov), .match_cnt(cnt_ov));

    seq_detector_param #(.PAT_W(4), .PAT_INIT(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_no (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pat_load(pat_load),
        .pat_in(pat_in), .z(z_no), .pat(pat_no), .match_cnt(cnt_no));

    seq_detector_param #(.PAT_W(4), .PAT_INIT(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pat_load(pat_load),
        .pat_in(pat_in), .z(z_sat), .pat(pat_sat), .match_cnt(cnt_sat));

    // Expected values are those observable during the cycle the inputs are applied.
    typedef struct {
        logic       rst, xv, ld, x;
        logic [3:0] pin;
        logic       zo, zn;
        logic [7:0] co, cn;
        logic [1:0] cs;
        logic [3:0] pat;
    } rec_t;

    rec_t tbl[$];
    rec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   row   = 0;

    function automatic rec_t mk(logic rst, logic xv, logic ld, logic xb, logic [3:0] pin,
                                logic zo, logic zn, int co, int cn, int cs, logic [3:0] pt);
        rec_t r;
        r.rst = rst; r.xv = xv; r.ld = ld; r.x = xb; r.pin = pin;
        r.zo = zo; r.zn = zn; r.co = 8'(co); r.cn = 8'(cn); r.cs = 2'(cs); r.pat = pt;
`ifndef SEQDET_MATCH_CNT_EN
        r.co = '0; r.cn = '0; r.cs = '0;
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %0h required %0h", name, row, act, exp);
        end
    endtask

    task automatic step(input rec_t r);
        rec_t e;
        @(negedge clk);
        reset = r.rst; x_valid = r.xv; pat_load = r.ld; x = r.x; pat_in = r.pin;
        sb.push_back(r);
        #2;
        e = sb.pop_front();
        chk("z_ov",    {7'd0, z_ov},  {7'd0, e.zo});
        chk("z_no",    {7'd0, z_no},  {7'd0, e.zn});
        chk("z_sat",   {7'd0, z_sat}, {7'd0, e.zo});
        chk("cnt_ov",  cnt_ov,        e.co);
        chk("cnt_no",  cnt_no,        e.cn);
        chk("cnt_sat", {6'd0, cnt_sat}, {6'd0, e.cs});
        chk("pat_ov",  {4'd0, pat_ov},  {4'd0, e.pat});
        chk("pat_no",  {4'd0, pat_no},  {4'd0, e.pat});
        $display("row %0d rst=%b xv=%b ld=%b x=%b | z=%b%b%b cnt=%0d/%0d/%0d pat=%b",
                 row, r.rst, r.xv, r.ld, r.x, z_ov, z_no, z_sat, cnt_ov, cnt_no, cnt_sat, pat_ov);
        row++;
    endtask

    localparam logic [3:0] B = 4'b1011;

    initial begin
        logic [15:0] stream, ov_mask, no_mask;
        int co, cn, cs;

        reset = 1'b1; x = 1'b0; x_valid = 1'b0; pat_load = 1'b0; pat_in = 4'd0;
        repeat (2) @(negedge clk);

        // reset state; z masked by reset even with a valid bit
        tbl.push_back(mk(1,1,0,1,0, 0,0, 0,0,0, B));
        // overlap vs non-overlap on 1,0,1,1,0,1,1
        tbl.push_back(mk(0,1,0,1,0, 0,0, 0,0,0, B));
        tbl.push_back(mk(0,1,0,0,0, 0,0, 0,0,0, B));
        tbl.push_back(mk(0,1,0,1,0, 0,0, 0,0,0, B));
        tbl.push_back(mk(0,1,0,1,0, 1,1, 0,0,0, B));
        tbl.push_back(mk(0,1,0,0,0, 0,0, 1,1,1, B));
        tbl.push_back(mk(0,1,0,1,0, 0,0, 1,1,1, B));
        tbl.push_back(mk(0,1,0,1,0, 1,0, 1,1,1, B));
        tbl.push_back(mk(0,0,0,1,0, 0,0, 2,1,2, B));
        tbl.push_back(mk(1,1,0,1,0, 0,0, 2,1,2, B));
        // 1,0,1,1 with three stall cycles between bits
        tbl.push_back(mk(0,1,0,1,0, 0,0, 0,0,0, B));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,0,0, 0,0, 0,0,0, B));
        tbl.push_back(mk(0,1,0,0,0, 0,0, 0,0,0, B));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,1,0, 0,0, 0,0,0, B));
        tbl.push_back(mk(0,1,0,1,0, 0,0, 0,0,0, B));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,1,0, 0,0, 0,0,0, B));
        tbl.push_back(mk(0,1,0,1,0, 1,1, 0,0,0, B));
        tbl.push_back(mk(0,0,0,0,0, 0,0, 1,1,1, B));
        // reload to 0110 after 1,0,1; the load-cycle bit would complete 1011
        tbl.push_back(mk(0,1,0,1,0, 0,0, 1,1,1, B));
        tbl.push_back(mk(0,1,0,0,0, 0,0, 1,1,1, B));
        tbl.push_back(mk(0,1,0,1,0, 0,0, 1,1,1, B));
        tbl.push_back(mk(0,1,1,1,4'b0110, 0,0, 1,1,1, B));
        tbl.push_back(mk(0,1,0,0,0, 0,0, 0,0,0, 4'b0110));
        tbl.push_back(mk(0,1,0,1,0, 0,0, 0,0,0, 4'b0110));
        tbl.push_back(mk(0,1,0,1,0, 0,0, 0,0,0, 4'b0110));
        tbl.push_back(mk(0,1,0,0,0, 1,1, 0,0,0, 4'b0110));
        tbl.push_back(mk(0,0,0,0,0, 0,0, 1,1,1, 4'b0110));
        // mid-pattern reset discards 1,0,1
        tbl.push_back(mk(1,0,0,0,0, 0,0, 1,1,1, 4'b0110));
        tbl.push_back(mk(0,1,0,1,0, 0,0, 0,0,0, B));
        tbl.push_back(mk(0,1,0,0,0, 0,0, 0,0,0, B));
        tbl.push_back(mk(0,1,0,1,0, 0,0, 0,0,0, B));
        tbl.push_back(mk(1,1,0,1,0, 0,0, 0,0,0, B));
        tbl.push_back(mk(0,1,0,1,0, 0,0, 0,0,0, B));
        // pattern 0000: fill gating, then overlapping matches saturate the 2-bit counter
        tbl.push_back(mk(0,0,1,0,4'b0000, 0,0, 0,0,0, B));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,0,0,0, 0,0, 0,0,0, 4'b0000));
        tbl.push_back(mk(0,1,0,0,0, 1,1, 0,0,0, 4'b0000));
        tbl.push_back(mk(0,1,0,0,0, 1,0, 1,1,1, 4'b0000));
        tbl.push_back(mk(0,1,0,0,0, 1,0, 2,1,2, 4'b0000));
        tbl.push_back(mk(0,1,0,0,0, 1,0, 3,1,3, 4'b0000));
        tbl.push_back(mk(0,1,0,0,0, 1,1, 4,1,3, 4'b0000));
        tbl.push_back(mk(0,0,0,0,0, 0,0, 5,2,3, 4'b0000));

        foreach (tbl[i]) step(tbl[i]);

        // Hand sequence: five back-to-back overlapping 1011 matches after reset.
        step(mk(1,0,0,0,0, 0,0, 5,2,3, 4'b0000));
        stream  = 16'b1011011011011011;
        ov_mask = 16'h9248;
        no_mask = 16'h8208;
        co = 0; cn = 0; cs = 0;
        for (int i = 0; i < 16; i++) begin
            step(mk(0,1,0,stream[15-i],0, ov_mask[i], no_mask[i], co, cn, cs, B));
            co += int'(ov_mask[i]);
            cn += int'(no_mask[i]);
            if (ov_mask[i] && cs < 3) cs++;
        end
        step(mk(0,0,0,0,0, 0,0, co, cn, cs, B));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
